// File: rtl/bnn_param_loader_if.sv
// Host-to-loader command and byte-stream handshake.
// The host drives commands and bytes; the loader answers with ready and status pulses.
interface bnn_param_loader_if;
  logic       cmd_start;
  logic [2:0] cmd_sel;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       load_done;
  logic       cmd_err;

  modport master (
    output cmd_start, cmd_sel, in_data, in_valid,
    input  in_ready, load_done, cmd_err
  );

  modport slave (
    input  cmd_start, cmd_sel, in_data, in_valid,
    output in_ready, load_done, cmd_err
  );
endinterface

// File: rtl/bnn_param_loader.sv
// Byte-stream loader that fills the flat image, kernel and MLP weight buses of BNN_Network.
// One section per command; bytes land little-endian by bit, trailing pad bits are dropped.
module bnn_param_loader #(
  parameter int unsigned IMG_WIDTH        = 30,
  parameter int unsigned BNN1_CHANL       = 8,
  parameter int unsigned BNN2_CHANL       = 16,
  parameter int unsigned KERNEL_WIDTH     = 3,
  parameter int unsigned OUTPUT_IMG_SIZE  = 6,
  parameter int unsigned MLP_OUTPUT_CHANL = 16,
  parameter int unsigned NUM_CLASS        = 10
) (
  input  logic clk,
  input  logic rst_n,
  bnn_param_loader_if.slave bus,
  output logic [IMG_WIDTH*IMG_WIDTH-1:0]                               buff,
  output logic [KERNEL_WIDTH*KERNEL_WIDTH*BNN1_CHANL-1:0]              bnn_layer1_kernel_in,
  output logic [KERNEL_WIDTH*KERNEL_WIDTH*BNN1_CHANL*BNN2_CHANL-1:0]   bnn_layer2_kernel_in,
  output logic [BNN2_CHANL*OUTPUT_IMG_SIZE*MLP_OUTPUT_CHANL-1:0]       mlp_layer1_weights,
  output logic [MLP_OUTPUT_CHANL*NUM_CLASS-1:0]                        mlp_layer2_weights,
  output logic [4:0]                                                   section_valid,
  output logic                                                         all_loaded
);
  localparam int unsigned IMG_SIZE = IMG_WIDTH * IMG_WIDTH;
  localparam int unsigned L1_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH * BNN1_CHANL;
  localparam int unsigned L2_SIZE  = L1_SIZE * BNN2_CHANL;
  localparam int unsigned M1_SIZE  = BNN2_CHANL * OUTPUT_IMG_SIZE * MLP_OUTPUT_CHANL;
  localparam int unsigned M2_SIZE  = MLP_OUTPUT_CHANL * NUM_CLASS;

  localparam int unsigned IMG_IW = $clog2(IMG_SIZE);
  localparam int unsigned L1_IW  = $clog2(L1_SIZE);
  localparam int unsigned L2_IW  = $clog2(L2_SIZE);
  localparam int unsigned M1_IW  = $clog2(M1_SIZE);
  localparam int unsigned M2_IW  = $clog2(M2_SIZE);
  localparam int unsigned OFF_W  = 11;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state, state_nx;
  logic [2:0]       sel;
  logic [7:0]       byte_cnt;
  logic [7:0]       last_byte;
  logic [OFF_W-1:0] off;
  logic             start_ok;
  logic             accept;
  logic [4:0]       sv_nx;

  assign off = {byte_cnt, 3'b000};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, accept strobe and next section-valid vector
  always_comb begin
    state_nx  = state;
    start_ok  = 1'b0;
    accept    = 1'b0;
    sv_nx     = section_valid;
    case (sel)
      3'd0:    last_byte = 8'((IMG_SIZE + 7) / 8 - 1);
      3'd1:    last_byte = 8'((L1_SIZE + 7) / 8 - 1);
      3'd2:    last_byte = 8'((L2_SIZE + 7) / 8 - 1);
      3'd3:    last_byte = 8'((M1_SIZE + 7) / 8 - 1);
      default: last_byte = 8'((M2_SIZE + 7) / 8 - 1);
    endcase
    case (state)
      IDLE: begin
        if (bus.cmd_start && (bus.cmd_sel <= 3'd4)) begin
          start_ok           = 1'b1;
          state_nx           = LOAD;
          sv_nx[bus.cmd_sel] = 1'b0;
        end
      end
      LOAD: begin
        accept = bus.in_valid;
        if (accept && (byte_cnt == last_byte)) begin
          state_nx   = DONE;
          sv_nx[sel] = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control registers and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel           <= 3'd0;
      byte_cnt      <= 8'd0;
      bus.in_ready  <= 1'b0;
      bus.load_done <= 1'b0;
      bus.cmd_err   <= 1'b0;
      section_valid <= 5'd0;
      all_loaded    <= 1'b0;
    end else begin
      bus.in_ready  <= (state_nx == LOAD);
      bus.load_done <= (state_nx == DONE);
      bus.cmd_err   <= (state == IDLE) && bus.cmd_start && (bus.cmd_sel > 3'd4);
      section_valid <= sv_nx;
      all_loaded    <= &sv_nx;
      if (start_ok) begin
        sel      <= bus.cmd_sel;
        byte_cnt <= 8'd0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 8'd1;
      end
    end
  end

  // Byte write into the selected section; bits past the section size are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buff                 <= '0;
      bnn_layer1_kernel_in <= '0;
      bnn_layer2_kernel_in <= '0;
      mlp_layer1_weights   <= '0;
      mlp_layer2_weights   <= '0;
    end else if (accept) begin
      for (int k = 0; k < 8; k++) begin
        case (sel)
          3'd0: if ((off + OFF_W'(k)) < OFF_W'(IMG_SIZE))
                  buff[IMG_IW'(off + OFF_W'(k))] <= bus.in_data[k];
          3'd1: if ((off + OFF_W'(k)) < OFF_W'(L1_SIZE))
                  bnn_layer1_kernel_in[L1_IW'(off + OFF_W'(k))] <= bus.in_data[k];
          3'd2: if ((off + OFF_W'(k)) < OFF_W'(L2_SIZE))
                  bnn_layer2_kernel_in[L2_IW'(off + OFF_W'(k))] <= bus.in_data[k];
          3'd3: if ((off + OFF_W'(k)) < OFF_W'(M1_SIZE))
                  mlp_layer1_weights[M1_IW'(off + OFF_W'(k))] <= bus.in_data[k];
          3'd4: if ((off + OFF_W'(k)) < OFF_W'(M2_SIZE))
                  mlp_layer2_weights[M2_IW'(off + OFF_W'(k))] <= bus.in_data[k];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: section loads, padding, stalls, misuse, reload and async reset.
// Expected buses come from hand constants and a small byte-placement model.
module tb_bnn_param_loader;
  logic clk = 1'b0;
  logic rst_n;

  logic [899:0]  buff;
  logic [71:0]   bnn_layer1_kernel_in;
  logic [1151:0] bnn_layer2_kernel_in;
  logic [1535:0] mlp_layer1_weights;
  logic [159:0]  mlp_layer2_weights;
  logic [4:0]    section_valid;
  logic          all_loaded;

  logic [899:0]  m_img;
  logic [71:0]   m_l1;
  logic [1151:0] m_l2;
  logic [1535:0] m_m1;
  logic [159:0]  m_m2;

  int n_tests = 0;
  int n_fail  = 0;

  bnn_param_loader_if bus ();

  bnn_param_loader dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (bus.slave),
    .buff                 (buff),
    .bnn_layer1_kernel_in (bnn_layer1_kernel_in),
    .bnn_layer2_kernel_in (bnn_layer2_kernel_in),
    .mlp_layer1_weights   (mlp_layer1_weights),
    .mlp_layer2_weights   (mlp_layer2_weights),
    .section_valid        (section_valid),
    .all_loaded           (all_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int s, input int i);
    case (s)
      0:       pat = 8'hFF;
      1:       pat = 8'(i + 1);
      2:       pat = 8'(i * 3);
      3:       pat = 8'(i) ^ 8'hA5;
      default: pat = 8'(i * 7 + 3);
    endcase
  endfunction

  // Reference placement: byte b, bit k -> section bit 8b+k, pad bits dropped
  task automatic mdl(input int s, input int b, input logic [7:0] d);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = 8 * b + k;
      case (s)
        0: if (idx < 900)  m_img[idx] = d[k];
        1: if (idx < 72)   m_l1[idx]  = d[k];
        2: if (idx < 1152) m_l2[idx]  = d[k];
        3: if (idx < 1536) m_m1[idx]  = d[k];
        default: if (idx < 160) m_m2[idx] = d[k];
      endcase
    end
  endtask

  task automatic start(input logic [2:0] s);
    bus.cmd_start = 1'b1;
    bus.cmd_sel   = s;
    cyc();
    bus.cmd_start = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it (bounded)
  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 20) begin
      cyc();
      n++;
    end
    if (!bus.in_ready) chk("accept_wait", 160'(bus.in_ready), 160'd1);
    cyc();
  endtask

  // Load n bytes; returns in the DONE cycle. poke>=0 pulses cmd_start sel=0 with that byte.
  task automatic load(input int s, input int n, input bit gap, input int poke);
    start(3'(s));
    chk($sformatf("ready_rise_s%0d", s), 160'(bus.in_ready), 160'd1);
    for (int i = 0; i < n; i++) begin
      if (i == poke) begin
        bus.cmd_start = 1'b1;
        bus.cmd_sel   = 3'd0;
      end
      send_byte(pat(s, i));
      mdl(s, i, pat(s, i));
      if (i == poke) begin
        bus.cmd_start = 1'b0;
        chk("poke_no_err", 160'(bus.cmd_err), 160'd0);
        chk("poke_still_ready", 160'(bus.in_ready), 160'd1);
      end
      if (i == n - 2) chk($sformatf("no_early_done_s%0d", s), 160'(bus.load_done), 160'd0);
      if (gap && i != n - 1) begin
        bus.in_valid = 1'b0;
        cyc();
      end
    end
    bus.in_valid = 1'b0;
    chk($sformatf("load_done_s%0d", s), 160'(bus.load_done), 160'd1);
    chk($sformatf("ready_drop_s%0d", s), 160'(bus.in_ready), 160'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_start = 1'b0;
    bus.cmd_sel   = 3'd0;
    bus.in_data   = 8'd0;
    bus.in_valid  = 1'b0;
    m_img = '0; m_l1 = '0; m_l2 = '0; m_m1 = '0; m_m2 = '0;
    cyc();
    cyc();
    chk("rst_ready", 160'(bus.in_ready), 160'd0);
    chk("rst_valid", 160'(section_valid), 160'd0);
    chk("rst_done_err", {bus.load_done, bus.cmd_err, all_loaded}, 160'd0);
    chk("rst_img", 160'($countones(buff)), 160'd0);
    rst_n = 1'b1;
    cyc();

    // in_valid outside LOAD is ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    chk("idle_ready", 160'(bus.in_ready), 160'd0);
    chk("idle_no_write", 160'(mlp_layer2_weights), 160'd0);

    // L1 kernel, back-to-back bytes 0x01..0x09
    load(1, 9, 1'b0, -1);
    chk("l1_kernel", 160'(bnn_layer1_kernel_in), 160'(72'h090807060504030201));
    chk("l1_valid", 160'(section_valid), 160'(5'b00010));
    cyc();
    chk("l1_done_pulse", 160'(bus.load_done), 160'd0);

    // Illegal select
    start(3'd6);
    chk("err_pulse", 160'(bus.cmd_err), 160'd1);
    chk("err_idle", 160'(bus.in_ready), 160'd0);
    cyc();
    chk("err_clear", 160'(bus.cmd_err), 160'd0);
    chk("err_still_idle", 160'(bus.in_ready), 160'd0);

    // Image, 113 x 0xFF; the 900-bit bus fills, pad bits dropped
    load(0, 113, 1'b0, -1);
    chk("img_all_ones", 160'($countones(buff)), 160'd900);
    chk("img_valid", 160'(section_valid), 160'(5'b00011));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    chk("img_no_114th", 160'($countones(buff)), 160'd900);

    // MLP2 with one idle cycle between bytes
    load(4, 20, 1'b1, -1);
    chk("m2_byte0", 160'(mlp_layer2_weights[7:0]), 160'(8'h03));
    chk("m2_byte19", 160'(mlp_layer2_weights[159:152]), 160'(8'h88));
    chk("m2_bus", 160'(mlp_layer2_weights), 160'(m_m2));
    cyc();

    // MLP1 with an ignored cmd_start mid-load
    load(3, 192, 1'b0, 50);
    chk("m1_diff", 160'($countones(mlp_layer1_weights ^ m_m1)), 160'd0);
    chk("m1_img_kept", 160'($countones(buff ^ m_img)), 160'd0);
    chk("m1_not_all", 160'(all_loaded), 160'd0);
    cyc();

    // Final section completes the set
    load(2, 144, 1'b0, -1);
    chk("l2_diff", 160'($countones(bnn_layer2_kernel_in ^ m_l2)), 160'd0);
    chk("all_valid", 160'(section_valid), 160'(5'b11111));
    chk("all_loaded", 160'(all_loaded), 160'd1);
    cyc();

    // Reload L2: valid drops at start, partial bytes overwrite only the front
    start(3'd2);
    chk("reload_valid", 160'(section_valid), 160'(5'b11011));
    chk("reload_not_all", 160'(all_loaded), 160'd0);
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h00);
      mdl(2, i, 8'h00);
    end
    bus.in_valid = 1'b0;
    chk("reload_partial", 160'($countones(bnn_layer2_kernel_in ^ m_l2)), 160'd0);
    chk("reload_busy", 160'(bus.in_ready), 160'd1);

    // Async reset mid-cycle, mid-load
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 160'(bus.in_ready), 160'd0);
    chk("arst_valid", {section_valid, all_loaded}, 160'd0);
    chk("arst_img", 160'($countones(buff)), 160'd0);
    chk("arst_l2", 160'($countones(bnn_layer2_kernel_in)), 160'd0);
    chk("arst_m1", 160'($countones(mlp_layer1_weights)), 160'd0);
    chk("arst_small", {mlp_layer2_weights[87:0], bnn_layer1_kernel_in}, 160'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", 160'(bus.in_ready), 160'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
